// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: blank codes, the hex glyph
// table and the digit index type.
package seg7_pkg;

   localparam logic [6:0] SEG_OFF = 7'h7F;
   localparam logic [3:0] AN_OFF  = 4'hF;

   // Active-low {g,f,e,d,c,b,a} glyphs, indexed by nibble value 0..F.
   localparam logic [6:0] HEX_SEG [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   typedef logic [1:0] digit_idx_t;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low 7-segment glyph lookup.
module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg_n
);

   assign seg_n = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Counter display stage: samples q, counts F->0 wraps and scans four
// common-anode digits (digit 0 = live count, digits 1..3 = wrap count).
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int REFRESH_DIV = 50000,
   parameter bit LZB         = 1'b1
)(
   input  logic        clk,
   input  logic        rs,
   input  logic [3:0]  q,
   output logic [6:0]  seg,
   output logic [3:0]  an,
   output logic [11:0] wrap_cnt,
   output logic        wrap_pulse
);

   localparam int PC_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [PC_W-1:0] PC_MAX = PC_W'(REFRESH_DIV - 1);

   logic [3:0]      q_d_q, q_d_d;
   logic [11:0]     wrap_cnt_q, wrap_cnt_d;
   logic            wrap_pulse_q, wrap_pulse_d;
   logic [PC_W-1:0] pc_q, pc_d;
   digit_idx_t      di_q, di_d;
   logic [6:0]      seg_q, seg_d;
   logic [3:0]      an_q, an_d;

   logic            wrap_hit;
   logic [3:0]      nibble;
   logic            digit_blank;
   logic [6:0]      dec_seg;

   seg7_hex_decode u_dec (
      .nibble (nibble),
      .seg_n  (dec_seg)
   );

   always_comb begin
      q_d_d        = q;
      // Only a genuine F->0 rollover counts; upstream resets or skips do not.
      wrap_hit     = (q_d_q == 4'hF) && (q == 4'h0);
      wrap_pulse_d = wrap_hit;
      wrap_cnt_d   = wrap_hit ? wrap_cnt_q + 12'd1 : wrap_cnt_q;
      pc_d         = (pc_q == PC_MAX) ? '0 : pc_q + PC_W'(1);
      di_d         = (pc_q == PC_MAX) ? di_q + 2'd1 : di_q;
   end

   always_comb begin
      nibble      = q_d_q;
      digit_blank = 1'b0;
      case (di_q)
         2'd0: nibble = q_d_q;
         2'd1: begin
            nibble      = wrap_cnt_q[3:0];
            digit_blank = LZB && (wrap_cnt_q == 12'd0);
         end
         2'd2: begin
            nibble      = wrap_cnt_q[7:4];
            digit_blank = LZB && (wrap_cnt_q[11:4] == 8'd0);
         end
         default: begin
            nibble      = wrap_cnt_q[11:8];
            digit_blank = LZB && (wrap_cnt_q[11:8] == 4'd0);
         end
      endcase

      // First cycle of every slot stays dark so the previous glyph never
      // ghosts onto the newly selected anode.
      if ((pc_q == '0) || digit_blank) begin
         seg_d = SEG_OFF;
         an_d  = AN_OFF;
      end else begin
         seg_d = dec_seg;
         an_d  = ~(4'b0001 << di_q);
      end
   end

   always_ff @(posedge clk or posedge rs) begin
      if (rs) begin
         q_d_q        <= 4'h0;
         wrap_cnt_q   <= 12'h000;
         wrap_pulse_q <= 1'b0;
         pc_q         <= '0;
         di_q         <= 2'd0;
         seg_q        <= SEG_OFF;
         an_q         <= AN_OFF;
      end else begin
         q_d_q        <= q_d_d;
         wrap_cnt_q   <= wrap_cnt_d;
         wrap_pulse_q <= wrap_pulse_d;
         pc_q         <= pc_d;
         di_q         <= di_d;
         seg_q        <= seg_d;
         an_q         <= an_d;
      end
   end

   assign seg        = seg_q;
   assign an         = an_q;
   assign wrap_cnt   = wrap_cnt_q;
   assign wrap_pulse = wrap_pulse_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: two instances (blanking on/off) share stimulus
// and are checked every cycle against a frame-position display model.
module tb_seg7_scan_driver;

   localparam int RD = 4;

   logic        clk = 1'b0;
   logic        rs  = 1'b0;
   logic [3:0]  q   = 4'h0;
   logic [6:0]  seg1, seg0;
   logic [3:0]  an1, an0;
   logic [11:0] wc1, wc0;
   logic        wp1, wp0;

   int tests_run    = 0;
   int tests_failed = 0;

   // Model state: edges since reset release, last sampled q, wraps so far.
   int         m_cycle = 0;
   logic [3:0] m_qd    = 4'h0;
   int         m_wraps = 0;

   logic [6:0] glyph [16];
   logic [3:0] an_sel [4];

   typedef struct {
      logic [3:0] q;
      logic [3:0] an;
      logic [6:0] seg;
   } vec_t;
   vec_t vecs [20];

   seg7_scan_driver #(.REFRESH_DIV(RD), .LZB(1'b1)) u1 (
      .clk(clk), .rs(rs), .q(q), .seg(seg1), .an(an1),
      .wrap_cnt(wc1), .wrap_pulse(wp1)
   );

   seg7_scan_driver #(.REFRESH_DIV(RD), .LZB(1'b0)) u0 (
      .clk(clk), .rs(rs), .q(q), .seg(seg0), .an(an0),
      .wrap_cnt(wc0), .wrap_pulse(wp0)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      tests_run++;
      if (act != exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // What the display should show for frame position (pc, di).
   task automatic model_disp(input int pc, input int di, input bit lzb,
                             output logic [3:0] e_an, output logic [6:0] e_seg);
      int val;
      int wr;
      bit blank;
      wr    = m_wraps % 4096;
      blank = 1'b0;
      if (di == 0) val = m_qd;
      else begin
         val = (wr >> (4 * (di - 1))) % 16;
         if (lzb && wr < (1 << (4 * (di - 1)))) blank = 1'b1;
      end
      if (pc == 0 || blank) begin
         e_an  = 4'hF;
         e_seg = 7'h7F;
      end else begin
         e_an  = an_sel[di];
         e_seg = glyph[val];
      end
   endtask

   // Drive q, take one clock edge, advance the model and compare both DUTs.
   task automatic cycle(input logic [3:0] qv);
      logic [3:0] e_an1, e_an0;
      logic [6:0] e_seg1, e_seg0;
      bit w;
      q = qv;
      @(posedge clk);
      model_disp(m_cycle % RD, (m_cycle / RD) % 4, 1'b1, e_an1, e_seg1);
      model_disp(m_cycle % RD, (m_cycle / RD) % 4, 1'b0, e_an0, e_seg0);
      w = (m_qd == 4'hF) && (qv == 4'h0);
      m_qd = qv;
      if (w) m_wraps = (m_wraps + 1) % 4096;
      m_cycle++;
      #1;
      check("seg_lzb1", seg1, e_seg1);
      check("an_lzb1", an1, e_an1);
      check("seg_lzb0", seg0, e_seg0);
      check("an_lzb0", an0, e_an0);
      check("wrap_cnt_lzb1", wc1, m_wraps);
      check("wrap_cnt_lzb0", wc0, m_wraps);
      check("wrap_pulse_lzb1", wp1, w);
      check("wrap_pulse_lzb0", wp0, w);
   endtask

   // Called just after an edge: asserts rs mid-cycle, checks the async clear,
   // holds through two edges and releases away from the clock edge.
   task automatic apply_reset();
      #2 rs = 1'b1;
      #1;
      check("rst_seg", seg1, 7'h7F);
      check("rst_an", an1, 4'hF);
      check("rst_wrap_cnt", wc1, 0);
      check("rst_wrap_pulse", wp1, 0);
      check("rst_seg_lzb0", seg0, 7'h7F);
      check("rst_an_lzb0", an0, 4'hF);
      @(posedge clk);
      @(posedge clk);
      #1;
      rs      = 1'b0;
      q       = 4'h0;
      m_cycle = 0;
      m_qd    = 4'h0;
      m_wraps = 0;
   endtask

   initial begin
      logic [3:0] last_q;
      int cnt_a, cnt_b;

      glyph = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      an_sel = '{4'hE, 4'hD, 4'hB, 4'h7};

      // Post-reset frames with no wraps, LZB=1: expected output after each edge.
      vecs[0]  = '{4'h5, 4'hF, 7'h7F};
      vecs[1]  = '{4'hA, 4'hE, 7'h12};
      vecs[2]  = '{4'h3, 4'hE, 7'h08};
      vecs[3]  = '{4'hC, 4'hE, 7'h30};
      vecs[4]  = '{4'h1, 4'hF, 7'h7F};
      vecs[5]  = '{4'h2, 4'hF, 7'h7F};
      vecs[6]  = '{4'h4, 4'hF, 7'h7F};
      vecs[7]  = '{4'h6, 4'hF, 7'h7F};
      vecs[8]  = '{4'h8, 4'hF, 7'h7F};
      vecs[9]  = '{4'h9, 4'hF, 7'h7F};
      vecs[10] = '{4'hF, 4'hF, 7'h7F};
      vecs[11] = '{4'hF, 4'hF, 7'h7F};
      vecs[12] = '{4'h1, 4'hF, 7'h7F};
      vecs[13] = '{4'h2, 4'hF, 7'h7F};
      vecs[14] = '{4'h3, 4'hF, 7'h7F};
      vecs[15] = '{4'h4, 4'hF, 7'h7F};
      vecs[16] = '{4'h7, 4'hF, 7'h7F};
      vecs[17] = '{4'hE, 4'hE, 7'h78};
      vecs[18] = '{4'hB, 4'hE, 7'h06};
      vecs[19] = '{4'hD, 4'hE, 7'h03};

      // Power-on reset, checked before any clock edge.
      #1 rs = 1'b1;
      #2;
      check("por_seg", seg1, 7'h7F);
      check("por_an", an1, 4'hF);
      check("por_wrap_cnt", wc1, 0);
      check("por_wrap_pulse", wp1, 0);
      @(posedge clk);
      #1 rs = 1'b0;

      for (int i = 0; i < 20; i++) begin
         cycle(vecs[i].q);
         check($sformatf("vec%0d_an", i), an1, vecs[i].an);
         check($sformatf("vec%0d_seg", i), seg1, vecs[i].seg);
      end

      // Mid-frame reset, then a single E,F,0 wrap.
      cycle(4'h2);
      apply_reset();
      cycle(4'hE);
      cycle(4'hF);
      check("pre_wrap_pulse", wp1, 0);
      cycle(4'h0);
      check("wrap_pulse_set", wp1, 1);
      check("wrap_cnt_one", wc1, 1);
      cycle(4'h1);
      check("wrap_pulse_clear", wp1, 0);
      cycle(4'h2);
      cycle(4'h3);
      check("digit1_an", an1, 4'hD);
      check("digit1_seg", seg1, 7'h79);

      // Upstream-reset style 7->0 jump must not count.
      cycle(4'h7);
      cycle(4'h0);
      check("jump_no_pulse", wp1, 0);
      cycle(4'h5);
      check("jump_no_pulse2", wp1, 0);
      check("jump_wrap_cnt", wc1, 1);

      // Preload 4095 wraps, then roll the 12-bit count over.
      apply_reset();
      for (int i = 0; i < 4095; i++) begin
         cycle(4'hF);
         cycle(4'h0);
      end
      check("preload_wrap_cnt", wc1, 12'hFFF);
      cycle(4'hF);
      cycle(4'h0);
      check("rollover_pulse", wp1, 1);
      check("rollover_wrap_cnt", wc1, 0);
      cnt_a = 0;
      cnt_b = 0;
      for (int i = 0; i < 16; i++) begin
         cycle(4'h1);
         if (an1 != 4'hE && an1 != 4'hF) cnt_a++;
         if (an0 != 4'hE && an0 != 4'hF && seg0 == 7'h40) cnt_b++;
      end
      check("rollover_lzb1_upper_lit", cnt_a, 0);
      check("rollover_lzb0_zero_glyphs", cnt_b, 9);

      // Index sequence after release on the unblanked instance.
      apply_reset();
      for (int f = 0; f < 2; f++) begin
         for (int s = 0; s < 4; s++) begin
            cycle(4'h6);
            check("seq_blank_an", an0, 4'hF);
            for (int k = 0; k < RD - 1; k++) begin
               cycle(4'h6);
               check("seq_lit_an", an0, an_sel[s]);
            end
         end
      end

      // Randomized traffic with F->0 bias and occasional mid-frame resets.
      last_q = 4'h6;
      for (int i = 0; i < 1500; i++) begin
         logic [3:0] qv;
         qv = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) qv = (last_q == 4'hF) ? 4'h0 : 4'hF;
         if ($urandom_range(0, 299) == 0) begin
            apply_reset();
            last_q = 4'h0;
         end
         cycle(qv);
         last_q = qv;
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
